beta2alpha_norm: RTL and testbench
==================================

// Module: beta2alpha_norm
// PURPOSE
//   Downstream of the MAC stage. Collects the serial beta stream (J*A beats per
//   frame) and normalises it per user in the log domain (value minus per-user max).
//   Re-emits the result as A columns of J values each, in the same column format
//   that alpha2xinitial and backbone_initial accept on alpha_u_col.
//   Ping-pong buffered, so beta is never back-pressured while one frame drains.
// PARAMETERS
//   J  14  number of users (values per output column)
//   I   7  resource count; carried for hierarchy consistency, unused inside
//   A   2  alphabet size (columns per frame)
// PORTS
//   clk                 in   1     single clock, rising edge
//   rst                 in   1     synchronous reset, active-high
//   beta                in   64    signed two's-complement beta value
//   beta_tvalid         in   1     beta beat valid (no ready; beats must be accepted)
//   alpha_u_col         out  J*64  column a; user j at bits [j*64 +: 64]
//   alpha_u_col_tvalid  out  1     column valid
//   alpha_u_col_tready  in   1     downstream accepts column
//   alpha_u_col_tlast   out  1     high on column a=A-1
//   frame_cnt           out  16    frames fully emitted (wraps at 2^16)
//   overflow            out  1     sticky: a beat arrived while both banks were busy
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): both banks EMPTY; write bank=0, read bank=0.
//   Write counters j=0, a=0; outputs tvalid=0, tlast=0, alpha_u_col=0,
//   frame_cnt=0, overflow=0.
// - A reset mid-frame discards all partial and full data. It takes priority over
//   every other event in that cycle.
// - Input order: j outer, a inner. Beat k of a frame is beta[j=k/A][a=k%A].
// - Each bank has four states: EMPTY -> FILL (first beat written) -> FULL (beat
//   J*A-1 written) -> DRAIN (first column presented) -> EMPTY (column A-1
//   accepted). A bank may begin FILL in the same cycle it becomes EMPTY.
// - Write side:
//   - On each accepted beat, store the value at [j][a] of the write bank.
//   - Track a running max per j: max[j] is loaded on a=0 and updated with the
//     signed compare on later beats.
//   - After beat J*A-1, the bank goes FULL and the write bank toggles.
// - Overflow: if beta_tvalid=1 while the write bank is not EMPTY/FILL (both banks
//   occupied), the beat is dropped, the counters hold, and overflow is set until
//   reset.
// - Read side: when the read bank is FULL, present column a=0 on the next cycle
//   (1-cycle latency from the last beat's edge).
//   - Output values: alpha_u_col[j] = beta[j][a] - max[j], a 64-bit signed
//     subtraction saturating at -2^63. The result is always <= 0, and the max
//     entry maps to exactly 0.
//   - A column is held stable while tvalid=1 and tready=0.
//   - On tvalid&tready, advance a. On a=A-1 with tlast=1, the bank goes EMPTY,
//     the read bank toggles, and frame_cnt increments.
//   - The next column may be presented on the cycle after a handshake
//     (throughput of 1 column/cycle).
// - Simultaneous events:
//   - The final beat into one bank and the final handshake out of the other in
//     the same cycle are both honoured; the freed bank is writable next cycle.
//   - A frame completing while the read bank is idle starts draining on the
//     next cycle.
// - Storage: 2*J*A*64 data bits plus 2*J*64 max bits. No floating point.
// TESTING
// 1. J=14, A=2. Frame with beta[j][0]=j, beta[j][1]=2j.
//    -> col0[j]=-j, col1[j]=0; tlast on col1; frame_cnt=1.
// 2. beta[3][0]=-2^63, beta[3][1]=2^63-1 -> col0[3]=-2^63 (saturated), col1[3]=0.
// 3. tready held 0 for 10 cycles after tvalid -> col0 stays stable.
//    The next frame's 28 beats still fill bank 1 with no overflow.
// 4. Three back-to-back frames with tready=0 throughout -> beats of frame 3
//    are dropped and overflow=1. After tready=1, frames 1 and 2 are emitted
//    intact and frame_cnt=2.
// 5. rst pulse after 15 beats -> no output. The next 28-beat frame emits
//    correctly from bank 0; overflow=0.
// 6. Continuous beats with tready=1 -> columns emitted with no gaps;
//    frame_cnt increments by 1 per frame.

Source files
------------

// File: rtl/beta2alpha_norm.sv
// beta2alpha_norm
//   Collects the serial beta stream of one frame (J*A beats, j outer, a inner),
//   tracks the per-user maximum and re-emits the frame as A columns of J values,
//   each value being beta[j][a] - max[j] (log-domain normalisation, saturating
//   at -2^63). Two banks ping-pong so that a frame can fill while the previous
//   one drains; the beta input is never back-pressured.
//
// Ports
//   clk                 clock, rising edge
//   rst                 synchronous reset, active-high
//   beta                signed 64-bit beta beat
//   beta_tvalid         beat valid (always accepted unless both banks occupied)
//   alpha_u_col         normalised column; user j at [j*64 +: 64]
//   alpha_u_col_tvalid  column valid
//   alpha_u_col_tready  downstream accepts column
//   alpha_u_col_tlast   marks column a = A-1
//   frame_cnt           frames fully emitted (wraps)
//   overflow            sticky: a beat was dropped because both banks were busy
//
// Bank FSM (one per bank)
//   state   | meaning
//   B_EMPTY | no data, writable
//   B_FILL  | at least one beat written, frame incomplete
//   B_FULL  | complete frame stored, waiting for the read side
//   B_DRAIN | columns being presented downstream
module beta2alpha_norm #(
   parameter int J = 14,
   parameter int I = 7,
   parameter int A = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [63:0]     beta,
   input  logic            beta_tvalid,
   output logic [J*64-1:0] alpha_u_col,
   output logic            alpha_u_col_tvalid,
   input  logic            alpha_u_col_tready,
   output logic            alpha_u_col_tlast,
   output logic [15:0]     frame_cnt,
   output logic            overflow
);

   localparam int JW = (J > 1) ? $clog2(J) : 1;
   localparam int AW = (A > 1) ? $clog2(A) : 1;
   localparam logic [JW-1:0] J_LAST = JW'(J - 1);
   localparam logic [AW-1:0] A_LAST = AW'(A - 1);

   // I only exists so the hierarchy carries the same parameter set everywhere.
   if (I < 1) begin : g_param_check
      $error("beta2alpha_norm: I must be positive");
   end

   typedef enum logic [1:0] {
      B_EMPTY = 2'd0,
      B_FILL  = 2'd1,
      B_FULL  = 2'd2,
      B_DRAIN = 2'd3
   } bank_st_t;

   bank_st_t st_q [2];
   bank_st_t st_d [2];

   logic [63:0] mem  [2][J][A];
   logic [63:0] maxv [2][J];

   logic          wr_bank;
   logic [JW-1:0] wr_j;
   logic [AW-1:0] wr_a;
   logic          rd_bank;
   logic [AW-1:0] rd_a;

   logic          rd_hs, rd_done, rd_start;
   logic          wr_open, wr_acc, wr_last;
   logic [AW-1:0] col_a;
   logic [J*64-1:0] col_val;

   always_comb begin
      rd_hs    = alpha_u_col_tvalid & alpha_u_col_tready;
      rd_done  = rd_hs & (rd_a == A_LAST);
      rd_start = ~alpha_u_col_tvalid & (st_q[rd_bank] == B_FULL);
      // A bank freed by the final handshake this cycle can take a beat at once.
      wr_open  = (st_q[wr_bank] == B_EMPTY) || (st_q[wr_bank] == B_FILL) ||
                 (rd_done && (rd_bank == wr_bank));
      wr_acc   = beta_tvalid & wr_open;
      wr_last  = wr_acc & (wr_j == J_LAST) & (wr_a == A_LAST);
   end

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         st_d[b] = st_q[b];
      end
      if (rd_start) begin
         st_d[rd_bank] = B_DRAIN;
      end
      if (rd_done) begin
         st_d[rd_bank] = B_EMPTY;
      end
      if (wr_acc) begin
         st_d[wr_bank] = wr_last ? B_FULL : B_FILL;
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
         st_q[b] <= rst ? B_EMPTY : st_d[b];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_bank][wr_j][wr_a] <= beta;
         if (wr_a == '0 || $signed(beta) > $signed(maxv[wr_bank][wr_j])) begin
            maxv[wr_bank][wr_j] <= beta;
         end
      end
   end

   // Column to load next: a=0 when a full bank starts draining, else a+1.
   // The 65-bit difference saturates when its top two bits disagree.
   always_comb begin
      logic [64:0] d;
      d       = '0;
      col_val = '0;
      col_a   = rd_start ? '0 : rd_a + 1'b1;
      for (int j = 0; j < J; j++) begin
         d = {mem[rd_bank][j][col_a][63], mem[rd_bank][j][col_a]} -
             {maxv[rd_bank][j][63], maxv[rd_bank][j]};
         if (d[64] != d[63]) begin
            col_val[j*64 +: 64] = 64'h8000_0000_0000_0000;
         end else begin
            col_val[j*64 +: 64] = d[63:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank            <= 1'b0;
         wr_j               <= '0;
         wr_a               <= '0;
         rd_bank            <= 1'b0;
         rd_a               <= '0;
         alpha_u_col        <= '0;
         alpha_u_col_tvalid <= 1'b0;
         alpha_u_col_tlast  <= 1'b0;
         frame_cnt          <= '0;
         overflow           <= 1'b0;
      end else begin
         if (wr_acc) begin
            if (wr_last) begin
               wr_j    <= '0;
               wr_a    <= '0;
               wr_bank <= ~wr_bank;
            end else if (wr_a == A_LAST) begin
               wr_a <= '0;
               wr_j <= wr_j + 1'b1;
            end else begin
               wr_a <= wr_a + 1'b1;
            end
         end
         if (beta_tvalid && !wr_open) begin
            overflow <= 1'b1;
         end

         if (rd_start || (rd_hs && !rd_done)) begin
            alpha_u_col_tvalid <= 1'b1;
            alpha_u_col        <= col_val;
            alpha_u_col_tlast  <= (col_a == A_LAST);
            rd_a               <= col_a;
         end else if (rd_done) begin
            alpha_u_col_tvalid <= 1'b0;
            alpha_u_col_tlast  <= 1'b0;
            rd_a               <= '0;
            rd_bank            <= ~rd_bank;
            frame_cnt          <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_beta2alpha_norm.sv
module tb_beta2alpha_norm;
   localparam int J = 14;
   localparam int A = 2;
   localparam int N = J * A;

   logic            clk = 1'b0;
   logic            rst;
   logic [63:0]     beta;
   logic            beta_tvalid;
   logic [J*64-1:0] alpha_u_col;
   logic            alpha_u_col_tvalid;
   logic            alpha_u_col_tready;
   logic            alpha_u_col_tlast;
   logic [15:0]     frame_cnt;
   logic            overflow;

   always #5 clk = ~clk;

   beta2alpha_norm #(.J(J), .I(7), .A(A)) dut (
      .clk                (clk),
      .rst                (rst),
      .beta               (beta),
      .beta_tvalid        (beta_tvalid),
      .alpha_u_col        (alpha_u_col),
      .alpha_u_col_tvalid (alpha_u_col_tvalid),
      .alpha_u_col_tready (alpha_u_col_tready),
      .alpha_u_col_tlast  (alpha_u_col_tlast),
      .frame_cnt          (frame_cnt),
      .overflow           (overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [J*64-1:0] col;
      bit              last;
   } col_t;

   col_t        exp_q[$];
   logic [63:0] fb[N];
   int          k_m        = 0;
   int          complete_m = 0;
   logic [15:0] fcnt_m     = '0;
   bit          ovf_m      = 1'b0;
   bit          hs_nonlast = 1'b0;

   function automatic logic [63:0] norm(input logic [63:0] v, input logic [63:0] m);
      logic signed [64:0] d;
      logic signed [64:0] lim;
      lim = {2'b11, 63'd0};
      d   = $signed({v[63], v}) - $signed({m[63], m});
      if (d < lim) return 64'h8000_0000_0000_0000;
      return d[63:0];
   endfunction

   task automatic push_frame();
      logic [63:0] mx[J];
      col_t c;
      for (int j = 0; j < J; j++) begin
         mx[j] = fb[j*A];
         for (int a = 1; a < A; a++)
            if ($signed(fb[j*A+a]) > $signed(mx[j])) mx[j] = fb[j*A+a];
      end
      for (int a = 0; a < A; a++) begin
         for (int j = 0; j < J; j++) c.col[j*64 +: 64] = norm(fb[j*A+a], mx[j]);
         c.last = (a == A - 1);
         exp_q.push_back(c);
      end
   endtask

   always @(posedge clk) begin
      hs_nonlast = 1'b0;
      if (rst) begin
         exp_q.delete();
         k_m = 0; complete_m = 0; fcnt_m = '0; ovf_m = 1'b0;
      end else begin
         if (alpha_u_col_tvalid && alpha_u_col_tready && exp_q.size() > 0) begin
            if (exp_q[0].last) begin
               complete_m--;
               fcnt_m++;
            end else begin
               hs_nonlast = 1'b1;
            end
            void'(exp_q.pop_front());
         end
         if (beta_tvalid) begin
            if (k_m > 0 || complete_m < 2) begin
               fb[k_m] = beta;
               k_m++;
               if (k_m == N) begin
                  push_frame();
                  complete_m++;
                  k_m = 0;
               end
            end else begin
               ovf_m = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int idle = 0;
   always @(negedge clk) begin
      if (!rst) begin
         check("frame_cnt", {48'd0, frame_cnt}, {48'd0, fcnt_m});
         check("overflow", {63'd0, overflow}, {63'd0, ovf_m});
         if (alpha_u_col_tvalid) begin
            idle = 0;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL spurious_tvalid: got tvalid=1, expected no column pending");
            end else begin
               int bad;
               bad = -1;
               for (int j = J - 1; j >= 0; j--)
                  if (alpha_u_col[j*64 +: 64] !== exp_q[0].col[j*64 +: 64]) bad = j;
               if (bad >= 0) begin
                  n_fail++;
                  $display("FAIL column_user%0d: got %h, expected %h", bad,
                           alpha_u_col[bad*64 +: 64], exp_q[0].col[bad*64 +: 64]);
               end
               check("tlast", {63'd0, alpha_u_col_tlast}, {63'd0, exp_q[0].last});
            end
         end else begin
            if (hs_nonlast) begin
               n_tests++;
               n_fail++;
               $display("FAIL column_gap: got tvalid=0, expected next column");
            end
            if (exp_q.size() > 0) begin
               idle++;
               if (idle > 2) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL present_latency: got tvalid=0 for %0d cycles, expected column", idle);
                  idle = 0;
               end
            end else begin
               idle = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [63:0] gen(input int kind, input int f, input int k);
      int j, a;
      logic [31:0] h;
      j = k / A;
      a = k % A;
      if (kind == 0) return (a == 0) ? 64'(j) : 64'(2 * j);
      if (kind == 1) begin
         if (j == 3) return (a == 0) ? 64'h8000_0000_0000_0000 : 64'h7fff_ffff_ffff_ffff;
         return 64'(j * 5 + a);
      end
      h = 32'(f) * 32'd2654435761 + 32'(k) * 32'd40503;
      return {h ^ 32'h5a5a_0000, h * 32'd7 + 32'(k)};
   endfunction

   task automatic send_frame(input int kind, input int f, input int nbeats);
      for (int k = 0; k < nbeats; k++) begin
         beta        = gen(kind, f, k);
         beta_tvalid = 1'b1;
         @(negedge clk);
      end
      beta_tvalid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int b;
      b = 0;
      while (!alpha_u_col_tvalid && b < 50) begin
         @(negedge clk);
         b++;
      end
      check(name, {63'd0, alpha_u_col_tvalid}, 64'd1);
   endtask

   task automatic wait_drain(input string name);
      int b;
      b = 0;
      while ((exp_q.size() > 0 || alpha_u_col_tvalid) && b < 400) begin
         @(negedge clk);
         b++;
      end
      check(name, {63'd0, alpha_u_col_tvalid}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; beta = '0; beta_tvalid = 1'b0; alpha_u_col_tready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", {63'd0, alpha_u_col_tvalid}, 64'd0);
      check("rst_tlast", {63'd0, alpha_u_col_tlast}, 64'd0);
      check("rst_col", {63'd0, |alpha_u_col}, 64'd0);
      check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
      check("rst_overflow", {63'd0, overflow}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // ramp frame: col0[j] = -j, col1[j] = 0
      alpha_u_col_tready = 1'b1;
      send_frame(0, 0, N);
      wait_valid("t1_valid");
      check("t1_col0_j0", alpha_u_col[0*64 +: 64], 64'd0);
      check("t1_col0_j5", alpha_u_col[5*64 +: 64], -64'sd5);
      check("t1_col0_j13", alpha_u_col[13*64 +: 64], -64'sd13);
      check("t1_tlast0", {63'd0, alpha_u_col_tlast}, 64'd0);
      @(negedge clk);
      check("t1_col1_j5", alpha_u_col[5*64 +: 64], 64'd0);
      check("t1_col1_j13", alpha_u_col[13*64 +: 64], 64'd0);
      check("t1_tlast1", {63'd0, alpha_u_col_tlast}, 64'd1);
      wait_drain("t1_drain");
      check("t1_frame_cnt", {48'd0, frame_cnt}, 64'd1);

      // saturation at -2^63
      send_frame(1, 0, N);
      wait_valid("t2_valid");
      check("t2_col0_j3", alpha_u_col[3*64 +: 64], 64'h8000_0000_0000_0000);
      check("t2_col0_j4", alpha_u_col[4*64 +: 64], -64'sd1);
      @(negedge clk);
      check("t2_col1_j3", alpha_u_col[3*64 +: 64], 64'd0);
      wait_drain("t2_drain");
      check("t2_frame_cnt", {48'd0, frame_cnt}, 64'd2);

      // backpressure: column held while the second bank fills
      alpha_u_col_tready = 1'b0;
      send_frame(2, 1, N);
      send_frame(2, 2, N);
      check("t3_overflow", {63'd0, overflow}, 64'd0);
      check("t3_held", {63'd0, alpha_u_col_tvalid}, 64'd1);
      alpha_u_col_tready = 1'b1;
      wait_drain("t3_drain");
      check("t3_frame_cnt", {48'd0, frame_cnt}, 64'd4);

      // three frames with no drain: third is dropped
      alpha_u_col_tready = 1'b0;
      send_frame(2, 3, N);
      send_frame(2, 4, N);
      send_frame(2, 5, N);
      check("t4_overflow", {63'd0, overflow}, 64'd1);
      alpha_u_col_tready = 1'b1;
      wait_drain("t4_drain");
      check("t4_frame_cnt", {48'd0, frame_cnt}, 64'd6);

      // reset mid-frame discards the partial frame
      send_frame(2, 6, 15);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_frame_cnt_rst", {48'd0, frame_cnt}, 64'd0);
      check("t5_tvalid_rst", {63'd0, alpha_u_col_tvalid}, 64'd0);
      send_frame(2, 7, N);
      wait_drain("t5_drain");
      check("t5_frame_cnt", {48'd0, frame_cnt}, 64'd1);
      check("t5_overflow", {63'd0, overflow}, 64'd0);

      // continuous streaming
      send_frame(2, 8, N);
      send_frame(2, 9, N);
      send_frame(2, 10, N);
      wait_drain("t6_drain");
      check("t6_frame_cnt", {48'd0, frame_cnt}, 64'd4);
      check("t6_overflow", {63'd0, overflow}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
